fix_tx_arbiter: RTL



---
 rtl/fix_tx_arbiter_pkg.sv | 21 ++
 rtl/fix_tx_arbiter_if.sv | 24 ++
 rtl/fix_tx_arbiter_ch_buffer.sv | 47 ++++
 rtl/fix_tx_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/fix_tx_arbiter_pkg.sv
// fix_tx_arbiter_pkg: shared states, buffer entry type and round-robin search for the tx arbiter
package fix_tx_arbiter_pkg;
  localparam int MAX_CH = 32;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_SEND = 1'b1;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;
  function automatic int rr_pick(input logic [MAX_CH-1:0] elig, input int n, input int start);
    int idx;
    rr_pick = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = start + i;
        if (idx >= n) idx -= n;
        if (elig[idx]) rr_pick = idx;
      end
    end
  endfunction
endpackage

// File: rtl/fix_tx_arbiter_if.sv
// fix_tx_arbiter_if: per-channel engine streams in, merged TOE stream out
interface fix_tx_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]      ch_write_i;
  logic [NUM_CH-1:0][7:0] ch_message_i;
  logic [NUM_CH-1:0]      ch_last_i;
  logic [NUM_CH-1:0]      ch_full_o;
  logic [NUM_CH-1:0]      ch_ovf_o;
  logic                   fifo_full_i;
  logic                   fifo_write_o;
  logic [7:0]             message_o;
  logic [CH_W-1:0]        channel_o;
  logic                   last_o;
  modport master (
    output ch_write_i, ch_message_i, ch_last_i, fifo_full_i,
    input  ch_full_o, ch_ovf_o, fifo_write_o, message_o, channel_o, last_o
  );
  modport slave (
    input  ch_write_i, ch_message_i, ch_last_i, fifo_full_i,
    output ch_full_o, ch_ovf_o, fifo_write_o, message_o, channel_o, last_o
  );
endinterface

// File: rtl/fix_tx_arbiter_ch_buffer.sv
// fix_ch_buffer: one channel's {last, byte} FIFO with byte and complete-message counts
module fix_ch_buffer
  import fix_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic       last,
  input  logic [7:0] data,
  input  logic       pop,
  output logic       full,
  output logic       ovf,
  output logic       eligible,
  output logic       avail,
  output entry_t     head
);
  localparam int AW = $clog2(DEPTH);
  entry_t        mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, msgs;
  logic          push;
  assign full     = cnt == (AW+1)'(DEPTH);
  assign push     = write && !full;
  // a full buffer is eligible so messages longer than DEPTH cut through
  assign eligible = msgs != '0 || full;
  assign avail    = cnt != '0;
  assign head     = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= {last, data};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      msgs <= '0;
      ovf  <= 1'b0;
    end else begin
      wp   <= wp + AW'(push);
      rp   <= rp + AW'(pop);
      cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      msgs <= msgs + (AW+1)'(push && last) - (AW+1)'(pop && head.last);
      ovf  <= ovf | (write && full);
    end
  end
endmodule

// File: rtl/fix_tx_arbiter.sv
// fix_tx_arbiter: merges NUM_CH FIX engine byte streams into one TOE stream, whole messages round-robin
module fix_tx_arbiter
  import fix_tx_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input logic             clk,
  input logic             rst,
  fix_tx_arbiter_if.slave bus
);
  logic [0:0]        state;
  logic [CH_W-1:0]   rr, grant;
  logic [NUM_CH-1:0] elig, avail, pop, full, ovf;
  entry_t            head [NUM_CH];
  entry_t            cur;
  logic              pop_en;
  int                pick;
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      fix_ch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .write    (bus.ch_write_i[c]),
        .last     (bus.ch_last_i[c]),
        .data     (bus.ch_message_i[c]),
        .pop      (pop[c]),
        .full     (full[c]),
        .ovf      (ovf[c]),
        .eligible (elig[c]),
        .avail    (avail[c]),
        .head     (head[c])
      );
    end
  endgenerate
  assign bus.ch_full_o = full;
  assign bus.ch_ovf_o  = ovf;
  always_comb begin
    cur    = head[grant];
    pop_en = state == ARB_SEND && !bus.fifo_full_i && avail[grant];
    pop    = pop_en ? NUM_CH'(1) << grant : '0;
    pick   = rr_pick(MAX_CH'(elig), NUM_CH, int'(rr));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ARB_IDLE;
      rr               <= '0;
      grant            <= '0;
      bus.fifo_write_o <= 1'b0;
      bus.message_o    <= '0;
      bus.channel_o    <= '0;
      bus.last_o       <= 1'b0;
    end else begin
      bus.fifo_write_o <= pop_en;
      if (pop_en) begin
        bus.message_o <= cur.data;
        bus.channel_o <= grant;
        bus.last_o    <= cur.last;
      end
      if (state == ARB_IDLE && pick >= 0) begin
        grant <= CH_W'(pick);
        state <= ARB_SEND;
      end
      // grant is released only when the last byte of the message leaves
      if (pop_en && cur.last) begin
        rr    <= grant == CH_W'(NUM_CH - 1) ? '0 : grant + CH_W'(1);
        state <= ARB_IDLE;
      end
    end
  end
endmodule
